hvac_zone_scheduler: RTL

Multi-zone scheduler that shares one heating/cooling plant between `NUM_ZONES` thermostatic zones. It watches each zone's 5-bit temperature and selects one zone at a time by round-robin. It opens that zone's damper and drives the plant in heat or cool mode. It enforces a minimum run time and a compressor lockout between runs. It sits above the air-conditioning datapath and replaces the single-zone `heating`/`cooling` decision with an arbitrated one.

---
 rtl/hvac_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/hvac_zone_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hvac_pkg.sv
// Shared constants and state/mode types for the multi-zone HVAC scheduler.
package hvac_pkg;

    localparam int unsigned TEMP_W = 5;

    localparam logic [TEMP_W-1:0] T_HEAT_ON  = 5'd18;
    localparam logic [TEMP_W-1:0] T_COOL_ON  = 5'd22;
    localparam logic [TEMP_W-1:0] T_SETPOINT = 5'd20;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLock
    } state_e;

    typedef enum logic {
        ModeHeat,
        ModeCool
    } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after last+1 (mod N).
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last) + k) % N);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Shares one heat/cool plant between zones with round-robin grants, minimum run and lockout.
// Optional HVAC_MAX_ON_EN caps each grant at MAX_ON cycles.
module hvac_zone_scheduler
    import hvac_pkg::*;
#(
    parameter int unsigned NUM_ZONES = 4,
    parameter int unsigned MIN_ON    = 8,
    parameter int unsigned MAX_ON    = 32,
    parameter int unsigned LOCKOUT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TEMP_W*NUM_ZONES-1:0]   zone_temp,
    input  logic [NUM_ZONES-1:0]          zone_en,
    output logic                          heating,
    output logic                          cooling,
    output logic [NUM_ZONES-1:0]          damper,
    output logic                          busy
);

    localparam int unsigned IW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int unsigned CW = $clog2(MAX_ON + 1);

    state_e               state_q;
    mode_e                mode_q;
    logic [IW-1:0]        zone_q;
    logic [IW-1:0]        last_q;
    logic [CW-1:0]        cnt_q;
    logic                 heating_q;
    logic                 cooling_q;
    logic [NUM_ZONES-1:0] damper_q;
    logic                 busy_q;

    logic [TEMP_W-1:0]    temp [NUM_ZONES];
    logic [NUM_ZONES-1:0] heat_dem;
    logic [NUM_ZONES-1:0] cool_dem;
    logic [NUM_ZONES-1:0] req;
    logic                 gnt_valid;
    logic [IW-1:0]        gnt_idx;
    logic [NUM_ZONES-1:0] gnt_onehot;
    logic [TEMP_W-1:0]    cur_temp;
    logic                 satisfied;
    logic                 min_done;
    logic                 lock_done;
    logic                 exit_run;
    logic [CW-1:0]        cnt_inc;

    always_comb begin
        for (int i = 0; i < int'(NUM_ZONES); i++) begin
            temp[i]     = zone_temp[TEMP_W*i +: TEMP_W];
            heat_dem[i] = zone_en[i] && (temp[i] <= T_HEAT_ON);
            cool_dem[i] = zone_en[i] && (temp[i] >= T_COOL_ON);
        end
    end

    assign req = heat_dem | cool_dem;

    rr_arbiter #(
        .N (NUM_ZONES)
    ) u_arb (
        .req       (req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_onehot = NUM_ZONES'(1) << gnt_idx;
    assign cur_temp   = temp[zone_q];
    assign satisfied  = (mode_q == ModeHeat) ? (cur_temp >= T_SETPOINT)
                                             : (cur_temp <= T_SETPOINT);
    assign min_done   = (32'(cnt_q) + 32'd1) >= MIN_ON;
    assign lock_done  = (32'(cnt_q) + 32'd1) >= LOCKOUT;
    // Counter saturates so a long unbounded run never wraps back below MIN_ON-1.
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

`ifdef HVAC_MAX_ON_EN
    assign exit_run = (min_done && satisfied) || ((32'(cnt_q) + 32'd1) >= MAX_ON);
`else
    assign exit_run = min_done && satisfied;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mode_q    <= ModeHeat;
            zone_q    <= '0;
            last_q    <= IW'(NUM_ZONES - 1);
            cnt_q     <= '0;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
            damper_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        state_q   <= StRun;
                        zone_q    <= gnt_idx;
                        mode_q    <= heat_dem[gnt_idx] ? ModeHeat : ModeCool;
                        cnt_q     <= '0;
                        heating_q <= heat_dem[gnt_idx];
                        cooling_q <= !heat_dem[gnt_idx];
                        damper_q  <= gnt_onehot;
                        busy_q    <= 1'b1;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_inc;
                    // Disable aborts the grant regardless of the minimum run time.
                    if (!zone_en[zone_q] || exit_run) begin
                        state_q   <= StLock;
                        last_q    <= zone_q;
                        cnt_q     <= '0;
                        heating_q <= 1'b0;
                        cooling_q <= 1'b0;
                        damper_q  <= '0;
                    end
                end
                StLock: begin
                    if (lock_done) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    heating_q <= 1'b0;
                    cooling_q <= 1'b0;
                    damper_q  <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign heating = heating_q;
    assign cooling = cooling_q;
    assign damper  = damper_q;
    assign busy    = busy_q;

endmodule
